// File: rtl/can_rx_ctrl.sv
// can_rx_ctrl: CAN receiver that samples once per bit, destuffs, decodes std/ext frames, checks CRC and framing, drives ACK.
module can_rx_ctrl (
   input  logic        clk,
   input  logic        nRST,
   input  logic        sample_strobe,
   input  logic        CANRX,
   input  logic        rx_enable,
   output logic        rx_busy,
   output logic [28:0] msg_id,
   output logic [63:0] data,
   output logic [3:0]  pkt_size,
   output logic        RTR,
   output logic        EXT,
   output logic        rx_done,
   output logic        ack_drive,
   output logic        stuff_error,
   output logic        crc_error,
   output logic        form_error
);

   typedef enum logic [4:0] {
      S_IDLE, S_ID, S_SRR_RTR, S_IDE, S_IDEXT, S_EXTRTR, S_R1, S_R0, S_DLC,
      S_DATA, S_CRC, S_CRCDEL, S_ACKSLOT, S_ACKDEL, S_EOF, S_INTER, S_ERROR
   } state_t;

   state_t      state;
   logic [6:0]  cnt;
   logic [2:0]  run_cnt;
   logic        run_lvl;
   logic [14:0] crc_reg, crc_rx;
   logic        crc_bad;
   logic [28:0] sh_id;
   logic [63:0] sh_data;
   logic [3:0]  sh_dlc, n_bytes;
   logic        sh_rtr, sh_ext;

   logic        in_stuff, sof, stuff_pos, crc_fb;
   logic [14:0] crc_nxt;
   logic [3:0]  dlc_full, n_bytes_nxt;
   logic [6:0]  data_last;

   // SOF through the last CRC bit is stuffed; a sixth bit after five equal ones is a stuff bit
   assign in_stuff    = state inside {S_ID, S_SRR_RTR, S_IDE, S_IDEXT, S_EXTRTR, S_R1, S_R0, S_DLC, S_DATA, S_CRC};
   assign sof         = sample_strobe && !CANRX && (state == S_IDLE || (state == S_INTER && cnt == 7'd2));
   assign stuff_pos   = in_stuff && run_cnt == 3'd5;
   assign crc_fb      = CANRX ^ crc_reg[14];
   assign crc_nxt     = {crc_reg[13:0], 1'b0} ^ (crc_fb ? 15'h4599 : 15'h0000);
   assign dlc_full    = {sh_dlc[2:0], CANRX};
   assign n_bytes_nxt = sh_rtr ? 4'd0 : (dlc_full[3] ? 4'd8 : dlc_full);
   assign data_last   = {n_bytes, 3'b000} - 7'd1;

   // frame FSM: destuffing, field capture, CRC, framing checks and registered outputs
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state       <= S_IDLE;
         cnt         <= '0;
         run_cnt     <= '0;
         run_lvl     <= 1'b0;
         crc_reg     <= '0;
         crc_rx      <= '0;
         crc_bad     <= 1'b0;
         sh_id       <= '0;
         sh_data     <= '0;
         sh_dlc      <= '0;
         n_bytes     <= '0;
         sh_rtr      <= 1'b0;
         sh_ext      <= 1'b0;
         rx_busy     <= 1'b0;
         msg_id      <= '0;
         data        <= '0;
         pkt_size    <= '0;
         RTR         <= 1'b0;
         EXT         <= 1'b0;
         rx_done     <= 1'b0;
         ack_drive   <= 1'b0;
         stuff_error <= 1'b0;
         crc_error   <= 1'b0;
         form_error  <= 1'b0;
      end else begin
         rx_done     <= 1'b0;
         stuff_error <= 1'b0;
         crc_error   <= 1'b0;
         form_error  <= 1'b0;
         if (!rx_enable) begin
            state     <= S_IDLE;
            ack_drive <= 1'b0;
            rx_busy   <= 1'b0;
         end else if (sof) begin
            state   <= S_ID;
            cnt     <= '0;
            run_cnt <= 3'd1;
            run_lvl <= 1'b0;
            crc_reg <= '0;
            crc_rx  <= '0;
            crc_bad <= 1'b0;
            sh_id   <= '0;
            sh_data <= '0;
            sh_dlc  <= '0;
            sh_rtr  <= 1'b0;
            sh_ext  <= 1'b0;
            rx_busy <= 1'b1;
         end else if (sample_strobe && stuff_pos) begin
            if (CANRX == run_lvl) begin
               stuff_error <= 1'b1;
               state       <= S_ERROR;
               cnt         <= '0;
            end else begin
               run_cnt <= 3'd1;
               run_lvl <= CANRX;
            end
         end else if (sample_strobe) begin
            if (in_stuff) begin
               run_cnt <= (CANRX == run_lvl) ? run_cnt + 3'd1 : 3'd1;
               run_lvl <= CANRX;
            end
            if (in_stuff && state != S_CRC)
               crc_reg <= crc_nxt;
            case (state)
               S_ID: begin
                  sh_id[28:18] <= {sh_id[27:18], CANRX};
                  state        <= (cnt == 7'd10) ? S_SRR_RTR : S_ID;
                  cnt          <= (cnt == 7'd10) ? 7'd0 : cnt + 7'd1;
               end
               S_SRR_RTR: begin
                  sh_rtr <= CANRX;
                  state  <= S_IDE;
               end
               S_IDE: begin
                  sh_ext <= CANRX;
                  state  <= CANRX ? S_IDEXT : S_R0;
                  cnt    <= '0;
               end
               S_IDEXT: begin
                  sh_id[17:0] <= {sh_id[16:0], CANRX};
                  state       <= (cnt == 7'd17) ? S_EXTRTR : S_IDEXT;
                  cnt         <= cnt + 7'd1;
               end
               S_EXTRTR: begin
                  sh_rtr <= CANRX;
                  state  <= S_R1;
               end
               S_R1: state <= S_R0;
               S_R0: begin
                  state <= S_DLC;
                  cnt   <= '0;
               end
               S_DLC: begin
                  sh_dlc  <= dlc_full;
                  n_bytes <= n_bytes_nxt;
                  state   <= (cnt != 7'd3) ? S_DLC : (n_bytes_nxt == 4'd0 ? S_CRC : S_DATA);
                  cnt     <= (cnt == 7'd3) ? 7'd0 : cnt + 7'd1;
               end
               S_DATA: begin
                  sh_data[{cnt[5:3], ~cnt[2:0]}] <= CANRX;
                  state <= (cnt == data_last) ? S_CRC : S_DATA;
                  cnt   <= (cnt == data_last) ? 7'd0 : cnt + 7'd1;
               end
               S_CRC: begin
                  crc_rx  <= {crc_rx[13:0], CANRX};
                  crc_bad <= {crc_rx[13:0], CANRX} != crc_reg;
                  state   <= (cnt == 7'd14) ? S_CRCDEL : S_CRC;
                  cnt     <= cnt + 7'd1;
               end
               S_CRCDEL: begin
                  form_error <= !CANRX;
                  ack_drive  <= CANRX && !crc_bad;
                  state      <= CANRX ? S_ACKSLOT : S_ERROR;
                  cnt        <= '0;
               end
               S_ACKSLOT: begin
                  ack_drive <= 1'b0;
                  state     <= S_ACKDEL;
               end
               S_ACKDEL: begin
                  form_error <= !CANRX;
                  crc_error  <= crc_bad;
                  state      <= (!CANRX || crc_bad) ? S_ERROR : S_EOF;
                  cnt        <= '0;
               end
               S_EOF: begin
                  if (cnt == 7'd6) begin
                     rx_done  <= 1'b1;
                     msg_id   <= sh_id;
                     data     <= sh_data;
                     pkt_size <= sh_dlc;
                     RTR      <= sh_rtr;
                     EXT      <= sh_ext;
                     state    <= S_INTER;
                     cnt      <= '0;
                  end else begin
                     form_error <= !CANRX;
                     state      <= CANRX ? S_EOF : S_ERROR;
                     cnt        <= CANRX ? cnt + 7'd1 : 7'd0;
                  end
               end
               S_INTER: begin
                  state   <= (cnt == 7'd2) ? S_IDLE : S_INTER;
                  rx_busy <= cnt != 7'd2;
                  cnt     <= cnt + 7'd1;
               end
               S_ERROR: begin
                  state   <= (CANRX && cnt == 7'd10) ? S_IDLE : S_ERROR;
                  rx_busy <= !(CANRX && cnt == 7'd10);
                  cnt     <= CANRX ? cnt + 7'd1 : 7'd0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_can_rx_ctrl.sv
// tb_can_rx_ctrl: directed frames built by a CAN encoder model, checked against hand-derived outputs.
module tb_can_rx_ctrl;

   logic        clk = 1'b0;
   logic        nRST = 1'b0;
   logic        sample_strobe = 1'b0;
   logic        CANRX = 1'b1;
   logic        rx_enable = 1'b1;
   logic        rx_busy;
   logic [28:0] msg_id;
   logic [63:0] data;
   logic [3:0]  pkt_size;
   logic        RTR, EXT, rx_done, ack_drive, stuff_error, crc_error, form_error;

   int n_checks = 0, n_errors = 0;
   int n_done = 0, n_ack = 0, n_stuff = 0, n_crc = 0, n_form = 0;
   int b_done, b_ack, b_stuff, b_crc, b_form;
   logic [28:0] id_at_done = '0;
   bit tx[$];
   int L;

   can_rx_ctrl dut (
      .clk(clk), .nRST(nRST), .sample_strobe(sample_strobe), .CANRX(CANRX), .rx_enable(rx_enable),
      .rx_busy(rx_busy), .msg_id(msg_id), .data(data), .pkt_size(pkt_size), .RTR(RTR), .EXT(EXT),
      .rx_done(rx_done), .ack_drive(ack_drive), .stuff_error(stuff_error), .crc_error(crc_error),
      .form_error(form_error)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // count pulse/ack cycles away from the active edge
   always @(negedge clk) begin
      if (rx_done) begin
         n_done++;
         id_at_done = msg_id;
      end
      if (ack_drive) n_ack++;
      if (stuff_error) n_stuff++;
      if (crc_error) n_crc++;
      if (form_error) n_form++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_done = n_done; b_ack = n_ack; b_stuff = n_stuff; b_crc = n_crc; b_form = n_form;
   endtask

   task automatic check_counts(input string tag, input int done, input int ack, input int st, input int cr, input int fo);
      check({tag, "_done"}, 64'(n_done - b_done), 64'(done));
      check({tag, "_ack"}, 64'(n_ack - b_ack), 64'(ack));
      check({tag, "_stuff"}, 64'(n_stuff - b_stuff), 64'(st));
      check({tag, "_crc"}, 64'(n_crc - b_crc), 64'(cr));
      check({tag, "_form"}, 64'(n_form - b_form), 64'(fo));
   endtask

   task automatic check_outputs(input string tag, input logic [28:0] id, input logic [63:0] d,
                                input logic [3:0] sz, input bit r, input bit e);
      check({tag, "_id"}, 64'(msg_id), 64'(id));
      check({tag, "_data"}, data, d);
      check({tag, "_size"}, 64'(pkt_size), 64'(sz));
      check({tag, "_rtr"}, 64'(RTR), 64'(r));
      check({tag, "_ext"}, 64'(EXT), 64'(e));
   endtask

   function automatic logic [14:0] crc_step(input logic [14:0] c, input bit b);
      logic x;
      x = b ^ c[14];
      c = {c[13:0], 1'b0};
      if (x) c = c ^ 15'h4599;
      return c;
   endfunction

   // encoder: raw fields, CRC (optionally one bit flipped), stuffing up to the last CRC bit, then the trailer
   task automatic build_frame(input logic [28:0] id, input bit ext, input bit rtr, input logic [3:0] dlc,
                              input logic [63:0] d, input int flip);
      bit raw[$];
      logic [14:0] c;
      int n, run;
      bit last;
      raw.push_back(1'b0);
      for (int i = 28; i >= 18; i--) raw.push_back(id[i]);
      if (ext) begin
         raw.push_back(1'b1);
         raw.push_back(1'b1);
         for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
         raw.push_back(rtr);
         raw.push_back(1'b0);
         raw.push_back(1'b0);
      end else begin
         raw.push_back(rtr);
         raw.push_back(1'b0);
         raw.push_back(1'b0);
      end
      for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
      n = rtr ? 0 : (dlc > 8 ? 8 : int'(dlc));
      for (int k = 0; k < n; k++)
         for (int i = 7; i >= 0; i--) raw.push_back(d[8*k+i]);
      c = '0;
      foreach (raw[i]) c = crc_step(c, raw[i]);
      for (int i = 14; i >= 0; i--) raw.push_back(c[i] ^ (flip == i));
      tx = {};
      run = 0;
      last = 1'b1;
      foreach (raw[i]) begin
         tx.push_back(raw[i]);
         if (raw[i] == last) run++;
         else begin
            run = 1;
            last = raw[i];
         end
         if (run == 5 && i != raw.size() - 1) begin
            tx.push_back(!raw[i]);
            last = !raw[i];
            run = 1;
         end
      end
      L = tx.size();
      tx.push_back(1'b1);
      tx.push_back(1'b0);
      tx.push_back(1'b1);
      repeat (10) tx.push_back(1'b1);
   endtask

   task automatic send_bit(input bit b);
      CANRX = b;
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_range(input int a, input int b);
      for (int i = a; i < b; i++) send_bit(tx[i]);
   endtask

   task automatic idle_bits(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(rx_busy), 0);
      check("rst_ack", 64'(ack_drive), 0);
      check("rst_done", 64'(rx_done), 0);
      check_outputs("rst", '0, '0, '0, 1'b0, 1'b0);
      nRST = 1'b1;
      @(negedge clk);
      idle_bits(2);

      // standard data frame
      snap();
      build_frame(29'h123 << 18, 1'b0, 1'b0, 4'd2, 64'h55AA, -1);
      send_bit(tx[0]);
      check("std_busy_sof", 64'(rx_busy), 1);
      send_range(1, tx.size() - 1);
      check("std_busy_int2", 64'(rx_busy), 1);
      send_bit(tx[tx.size() - 1]);
      check("std_busy_end", 64'(rx_busy), 0);
      check_counts("std", 1, 4, 0, 0, 0);
      check_outputs("std", 29'h123 << 18, 64'h55AA, 4'd2, 1'b0, 1'b0);
      check("std_id_at_done", 64'(id_at_done), 64'(29'h123 << 18));

      // extended remote frame
      snap();
      build_frame(29'h1ABCDEF1, 1'b1, 1'b1, 4'd4, 64'hDEAD, -1);
      send_range(0, tx.size());
      check_counts("extrtr", 1, 4, 0, 0, 0);
      check_outputs("extrtr", 29'h1ABCDEF1, 64'h0, 4'd4, 1'b1, 1'b1);

      // stuff error: sixth dominant sample counting SOF
      snap();
      repeat (5) send_bit(1'b0);
      check("stuff_pre", 64'(n_stuff - b_stuff), 0);
      send_bit(1'b0);
      check("stuff_hit", 64'(n_stuff - b_stuff), 1);
      idle_bits(10);
      check("stuff_busy10", 64'(rx_busy), 1);
      send_bit(1'b1);
      check("stuff_busy11", 64'(rx_busy), 0);
      check_counts("stuff", 0, 0, 1, 0, 0);
      check_outputs("stuff", 29'h1ABCDEF1, 64'h0, 4'd4, 1'b1, 1'b1);

      // CRC error
      snap();
      build_frame(29'h123 << 18, 1'b0, 1'b0, 4'd2, 64'h55AA, 3);
      send_range(0, tx.size());
      check("crc_busy", 64'(rx_busy), 1);
      send_bit(1'b1);
      check("crc_busy_after", 64'(rx_busy), 0);
      check_counts("crc", 0, 0, 0, 1, 0);
      check_outputs("crc", 29'h1ABCDEF1, 64'h0, 4'd4, 1'b1, 1'b1);

      // form error on EOF bit 3
      snap();
      build_frame(29'h2A5 << 18, 1'b0, 1'b0, 4'd1, 64'h0F, -1);
      tx[L + 2 + 3] = 1'b0;
      send_range(0, tx.size());
      idle_bits(12);
      check_counts("form", 0, 4, 0, 0, 1);
      check_outputs("form", 29'h1ABCDEF1, 64'h0, 4'd4, 1'b1, 1'b1);

      // dominant EOF bit 7 still completes the frame
      snap();
      build_frame(29'h2A5 << 18, 1'b0, 1'b0, 4'd1, 64'h0F, -1);
      tx[L + 2 + 7] = 1'b0;
      send_range(0, tx.size());
      check_counts("eof7", 1, 4, 0, 0, 0);
      check_outputs("eof7", 29'h2A5 << 18, 64'h0F, 4'd1, 1'b0, 1'b0);
      check("eof7_busy", 64'(rx_busy), 0);

      // reset during Data
      build_frame(29'h123 << 18, 1'b0, 1'b0, 4'd2, 64'h55AA, -1);
      send_range(0, 25);
      check("rstmid_busy_pre", 64'(rx_busy), 1);
      nRST = 1'b0;
      #2;
      check("rstmid_busy", 64'(rx_busy), 0);
      check_outputs("rstmid", '0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      nRST = 1'b1;
      @(negedge clk);

      // rx_enable low mid-frame
      snap();
      build_frame(29'h1ABCDEF1, 1'b1, 1'b0, 4'd1, 64'hC3, -1);
      send_range(0, 30);
      check("en_busy_pre", 64'(rx_busy), 1);
      rx_enable = 1'b0;
      @(negedge clk);
      check("en_busy", 64'(rx_busy), 0);
      send_range(30, tx.size());
      rx_enable = 1'b1;
      idle_bits(12);
      check_counts("en", 0, 0, 0, 0, 0);
      check_outputs("en", '0, '0, '0, 1'b0, 1'b0);

      // back-to-back: second SOF on intermission bit 3, second frame has DLC 9
      snap();
      build_frame(29'h123 << 18, 1'b0, 1'b0, 4'd2, 64'h55AA, -1);
      send_range(0, tx.size() - 1);
      check("b2b_first_done", 64'(n_done - b_done), 1);
      check_outputs("b2b_first", 29'h123 << 18, 64'h55AA, 4'd2, 1'b0, 1'b0);
      build_frame(29'h1ABCDEF1, 1'b1, 1'b0, 4'd9, 64'h0123456789ABCDEF, -1);
      send_range(0, tx.size());
      check_counts("b2b", 2, 8, 0, 0, 0);
      check_outputs("b2b_second", 29'h1ABCDEF1, 64'h0123456789ABCDEF, 4'd9, 1'b0, 1'b1);
      check("b2b_busy", 64'(rx_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
